sysid_probe_master: RTL

//  Avalon-MM read master that interrogates the system-ID slave (2 words: addr 0 = system ID,

---
 rtl/sysid_probe_master.sv | 81 ++++++++
 1 files changed

// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM read master that fetches and checks the system ID and build timestamp
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'hDEADBEEF,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5B92B311,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [2:0] {IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] tmo_cnt;
  logic [1:0] lat_cnt;
  logic auto_pend, is_cmd, is_wait, is_ts, accept, capture, expired, launch;
  always_comb begin
    is_cmd = state == ID_CMD || state == TS_CMD;
    is_wait = state == ID_WAIT || state == TS_WAIT;
    is_ts = state == TS_CMD || state == TS_WAIT;
    accept = is_cmd && !avm_waitrequest;
    capture = (accept && READ_LATENCY == 0) || (is_wait && lat_cnt == 2'(READ_LATENCY));
    expired = (is_cmd || is_wait) && tmo_cnt >= 16'(TIMEOUT_CYCLES - 1);
    launch = (state == IDLE && (start || auto_pend)) || (state == DONE && start);
    // acceptance and capture take priority over an expiring timeout
    state_nx = launch ? ID_CMD :
               capture ? (is_ts ? DONE : TS_CMD) :
               accept ? (is_ts ? TS_WAIT : ID_WAIT) :
               expired ? DONE : state;
    avm_read = is_cmd;
    avm_address = is_ts;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      auto_pend <= AUTO_START;
      tmo_cnt <= '0;
      lat_cnt <= '0;
      id_ok <= 1'b0;
      ts_ok <= 1'b0;
      timeout_err <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state <= state_nx;
      auto_pend <= 1'b0;
      tmo_cnt <= (state_nx != state && (state_nx == ID_CMD || state_nx == TS_CMD)) ? '0 :
                 (is_cmd || is_wait) ? tmo_cnt + 16'd1 : tmo_cnt;
      lat_cnt <= accept ? 2'd1 : is_wait ? lat_cnt + 2'd1 : lat_cnt;
      if (launch) begin
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
        timeout_err <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end else if (capture && is_ts) begin
        ts_value <= avm_readdata;
        ts_ok <= avm_readdata == EXPECTED_TIMESTAMP;
      end else if (capture) begin
        id_value <= avm_readdata;
        id_ok <= avm_readdata == EXPECTED_ID;
      end else if (expired && !accept) begin
        timeout_err <= 1'b1;
      end
    end
  end
endmodule
